vga_frame_box: RTL and testbench

- Parametrised VGA raster generator plus framed-rectangle renderer: border of configurable colour around an inner fill, runtime-adjustable thickness.
- Successor to the fixed-timing square printer: timing, colour depth, colours and thickness limits are parameters.
- Adds debounced push-button control, frame-synchronous (tear-free) updates, colour inversion and registered outputs.
- Sits directly between CLOCK_50 / KEY pins and the VGA DAC pins.

---
 rtl/vga_frame_pkg.sv | 31 +++
 rtl/key_pulse.sv | 43 ++++
 rtl/vga_frame_box.sv | 153 +++++++++++++++
 tb/tb_vga_frame_box.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_pkg.sv
// Shared constants and types for the framed-rectangle VGA generator.
package vga_frame_pkg;

    localparam int unsigned DEF_H_TOTAL      = 1586;
    localparam int unsigned DEF_H_SYNC       = 190;
    localparam int unsigned DEF_H_ACT_START  = 285;
    localparam int unsigned DEF_H_ACT_END    = 1555;
    localparam int unsigned DEF_V_TOTAL      = 526;
    localparam int unsigned DEF_V_SYNC       = 2;
    localparam int unsigned DEF_V_ACT_START  = 35;
    localparam int unsigned DEF_V_ACT_END    = 515;
    localparam int unsigned DEF_COLOR_W      = 4;
    localparam int unsigned DEF_DEBOUNCE_CYC = 500000;

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned KEY_INC  = 0;
    localparam int unsigned KEY_DEC  = 1;
    localparam int unsigned KEY_DEF  = 2;
    localparam int unsigned KEY_INV  = 3;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    function automatic int unsigned rgb_w(input int unsigned color_w);
        return 3 * color_w;
    endfunction

endpackage

// File: rtl/key_pulse.sv
// Push-button conditioner: 2-flop synchroniser, level debounce and a
// one-cycle pulse on an accepted press (active-low key going low).
module key_pulse #(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    assign settle = (cnt == CNT_W'(DEBOUNCE_CYC - 1));

    // cnt tracks how long the sampled level has differed from the accepted one
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync[1];
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_frame_box.sv
// VGA raster generator drawing a framed rectangle whose border thickness and
// colour inversion are button-controlled and only change on frame boundaries.
module vga_frame_box
    import vga_frame_pkg::*;
#(
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_ACT_START  = DEF_H_ACT_START,
    parameter int unsigned H_ACT_END    = DEF_H_ACT_END,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_ACT_START  = DEF_V_ACT_START,
    parameter int unsigned V_ACT_END    = DEF_V_ACT_END,
    parameter int unsigned COLOR_W      = DEF_COLOR_W,
    parameter int unsigned H_SCALE      = 2,
    parameter int unsigned C_DEFAULT    = 10,
    parameter int unsigned C_STEP       = 10,
    parameter int unsigned C_MAX        = 200,
    parameter logic [3*COLOR_W-1:0] BORDER_RGB = 12'hCCC,
    parameter logic [3*COLOR_W-1:0] FILL_RGB   = 12'h000,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic [3:0]         KEY,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               FRAME_START
);

    localparam int unsigned CX_W  = $clog2(H_TOTAL);
    localparam int unsigned CY_W  = $clog2(V_TOTAL);
    localparam int unsigned AW    = $clog2(H_TOTAL) + 2;
    localparam int unsigned C_W   = $clog2(C_MAX + 1);
    localparam int unsigned RGB_W = rgb_w(COLOR_W);

    logic [CX_W-1:0]     cx;
    logic [CY_W-1:0]     cy;
    logic                line_end;
    logic                frame_end;
    logic [NUM_KEYS-1:0] press;
    logic [C_W-1:0]      c_pend;
    logic [C_W-1:0]      c_act;
    logic [C_W-1:0]      c_nxt;
    logic                inv_pend;
    logic                inv_act;
    logic                inv_nxt;
    logic [AW-1:0]       inc_sum;
    logic [AW-1:0]       cxw, cyw, h_mar, v_mar, x_lo, x_hi, y_lo, y_hi;
    logic                act;
    logic                inner;
    logic [RGB_W-1:0]    pix;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
            .CLOCK_50 (CLOCK_50),
            .RESET    (RESET),
            .key_n    (KEY[k]),
            .press    (press[k])
        );
    end

    assign line_end  = (cx == CX_W'(H_TOTAL - 1));
    assign frame_end = line_end && (cy == CY_W'(V_TOTAL - 1));

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cx <= '0;
            cy <= '0;
        end else if (line_end) begin
            cx <= '0;
            cy <= frame_end ? '0 : cy + CY_W'(1);
        end else begin
            cx <= cx + CX_W'(1);
        end
    end

    assign inc_sum = AW'(c_pend) + AW'(C_STEP);

    // Next pending thickness: default wins, opposing presses cancel
    always_comb begin
        c_nxt = c_pend;
        if (press[KEY_DEF]) begin
            c_nxt = C_W'(C_DEFAULT);
        end else if (press[KEY_INC] && press[KEY_DEC]) begin
            c_nxt = c_pend;
        end else if (press[KEY_INC]) begin
            c_nxt = (inc_sum > AW'(C_MAX)) ? C_W'(C_MAX) : C_W'(inc_sum);
        end else if (press[KEY_DEC]) begin
            c_nxt = (AW'(c_pend) >= AW'(C_STEP)) ? C_W'(AW'(c_pend) - AW'(C_STEP)) : '0;
        end
        inv_nxt = inv_pend ^ press[KEY_INV];
    end

    // Commit uses the forwarded next values so a press in the last cycle counts
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            c_pend   <= C_W'(C_DEFAULT);
            c_act    <= C_W'(C_DEFAULT);
            inv_pend <= 1'b0;
            inv_act  <= 1'b0;
        end else begin
            c_pend   <= c_nxt;
            inv_pend <= inv_nxt;
            if (frame_end) begin
                c_act   <= c_nxt;
                inv_act <= inv_nxt;
            end
        end
    end

    assign cxw   = AW'(cx);
    assign cyw   = AW'(cy);
    assign h_mar = AW'(H_SCALE) * AW'(c_act);
    assign v_mar = AW'(c_act);
    assign x_lo  = AW'(H_ACT_START) + h_mar;
    assign x_hi  = (h_mar < AW'(H_ACT_END)) ? AW'(H_ACT_END) - h_mar : '0;
    assign y_lo  = AW'(V_ACT_START) + v_mar;
    assign y_hi  = (v_mar < AW'(V_ACT_END)) ? AW'(V_ACT_END) - v_mar : '0;

    assign act   = (cxw >= AW'(H_ACT_START)) && (cxw < AW'(H_ACT_END)) &&
                   (cyw >= AW'(V_ACT_START)) && (cyw < AW'(V_ACT_END));
    assign inner = (cxw >= x_lo) && (cxw < x_hi) && (cyw >= y_lo) && (cyw < y_hi);

    always_comb begin
        pix = '0;
        if (act) begin
            pix = (inner ? FILL_RGB : BORDER_RGB) ^ {RGB_W{inv_act}};
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            VGA_R       <= pix[RGB_W-1 -: COLOR_W];
            VGA_G       <= pix[2*COLOR_W-1 -: COLOR_W];
            VGA_B       <= pix[COLOR_W-1:0];
            VGA_HS      <= (cx >= CX_W'(H_SYNC));
            VGA_VS      <= (cy >= CY_W'(V_SYNC));
            FRAME_START <= (cx == '0) && (cy == '0);
        end
    end

endmodule

// File: tb/tb_vga_frame_box.sv
// Directed bench for vga_frame_box using a shrunken raster so whole frames
// can be captured and inspected pixel by pixel.
module tb_vga_frame_box;

    localparam int HT = 80, HS = 8, HA0 = 16, HA1 = 76;
    localparam int VT = 32, VS = 2, VA0 = 4, VA1 = 30;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] r, g, b;
    logic       hs, vs, fs;

    int total = 0;
    int bad   = 0;

    logic [11:0] fb   [FT];
    bit          hs_a [FT];
    bit          vs_a [FT];
    bit          fs_a [FT];

    always #5 clk = ~clk;

    vga_frame_box #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA0), .V_ACT_END(VA1),
        .COLOR_W(4), .H_SCALE(2), .C_DEFAULT(2), .C_STEP(2), .C_MAX(12),
        .BORDER_RGB(12'hCCC), .FILL_RGB(12'h000), .DEBOUNCE_CYC(4)
    ) dut (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .KEY         (key),
        .VGA_R       (r),
        .VGA_G       (g),
        .VGA_B       (b),
        .VGA_HS      (hs),
        .VGA_VS      (vs),
        .FRAME_START (fs)
    );

    function automatic int idx(input int x, input int y);
        return y * HT + x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs();
        int k = 0;
        while (fs !== 1'b1 && k < 2 * FT) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2 * FT) begin
            total++;
            bad++;
            $error("FAIL wait_fs: observed=timeout expected=frame_start");
        end
    endtask

    // Capture one frame; optionally hold keys in mask low for 10 cycles from index at
    task automatic capture(input logic [3:0] mask, input int at);
        wait_fs();
        for (int i = 0; i < FT; i++) begin
            fb[i]   = {r, g, b};
            hs_a[i] = hs;
            vs_a[i] = vs;
            fs_a[i] = fs;
            if (at >= 0 && i == at) key = 4'hF & ~mask;
            if (at >= 0 && i == at + 10) key = 4'hF;
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [3:0] mask);
        key = 4'hF & ~mask;
        repeat (10) @(negedge clk);
        key = 4'hF;
        repeat (12) @(negedge clk);
    endtask

    // Thickness c: inner starts at (HA0+2c, VA0+c) and ends before (HA1-2c, VA1-c)
    task automatic check_c(input int c, input string tag);
        chk({tag, " fill_tl"}, 32'(fb[idx(HA0 + 2*c, VA0 + c)]), 32'h000);
        if (c > 0) begin
            chk({tag, " border_l"}, 32'(fb[idx(HA0 + 2*c - 1, VA0 + c)]), 32'hCCC);
            chk({tag, " border_t"}, 32'(fb[idx(HA0 + 2*c, VA0 + c - 1)]), 32'hCCC);
            chk({tag, " fill_br"},  32'(fb[idx(HA1 - 2*c - 1, VA1 - c - 1)]), 32'h000);
            chk({tag, " border_r"}, 32'(fb[idx(HA1 - 2*c, VA1 - c - 1)]), 32'hCCC);
        end
    endtask

    initial begin
        int n_hs0, n_hs, n_vs, n_fs;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({r, g, b, hs, vs, fs}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_frame_start", 32'(fs), 32'h1);

        capture(4'h0, -1);
        n_hs0 = 0; n_hs = 0; n_vs = 0; n_fs = 0;
        for (int i = 0; i < FT; i++) begin
            if (!hs_a[i]) n_hs++;
            if (!hs_a[i] && i < HT) n_hs0++;
            if (!vs_a[i]) n_vs++;
            if (fs_a[i]) n_fs++;
        end
        chk("hs_low_line0", 32'(n_hs0), 32'd8);
        chk("hs_low_frame", 32'(n_hs), 32'd256);
        chk("vs_low_frame", 32'(n_vs), 32'd160);
        chk("fs_per_frame", 32'(n_fs), 32'd1);
        chk("vs_line1_end", 32'(vs_a[idx(79, 1)]), 32'h0);
        chk("vs_line2_start", 32'(vs_a[idx(0, 2)]), 32'h1);
        chk("hs_x7", 32'(hs_a[idx(7, 5)]), 32'h0);
        chk("hs_x8", 32'(hs_a[idx(8, 5)]), 32'h1);
        chk("px_first_active", 32'(fb[idx(16, 4)]), 32'hCCC);
        chk("px_first_inner", 32'(fb[idx(20, 6)]), 32'h000);
        chk("px_left_of_inner", 32'(fb[idx(19, 6)]), 32'hCCC);
        chk("px_above_inner", 32'(fb[idx(20, 5)]), 32'hCCC);
        chk("px_last_inner", 32'(fb[idx(71, 27)]), 32'h000);
        chk("px_right_border", 32'(fb[idx(72, 27)]), 32'hCCC);
        chk("px_last_active", 32'(fb[idx(75, 29)]), 32'hCCC);
        chk("px_blank_left", 32'(fb[idx(15, 4)]), 32'h000);
        chk("px_blank_right", 32'(fb[idx(76, 29)]), 32'h000);
        chk("px_blank_below", 32'(fb[idx(16, 30)]), 32'h000);

        capture(4'b0001, idx(0, 15));
        chk("midframe_unchanged", 32'(fb[idx(20, 20)]), 32'h000);
        check_c(2, "press_frame");
        capture(4'h0, -1);
        check_c(4, "after_inc");

        repeat (30) press(4'b0001);
        capture(4'h0, -1);
        check_c(12, "saturate");

        press(4'b0010);
        capture(4'h0, -1);
        check_c(10, "dec_from_max");

        press(4'b0100);
        press(4'b0010);
        press(4'b0010);
        capture(4'h0, -1);
        check_c(0, "dec_floor");
        chk("dec_floor corner", 32'(fb[idx(75, 29)]), 32'h000);

        press(4'b0100);
        press(4'b0001);
        press(4'b0011);
        capture(4'h0, -1);
        check_c(4, "inc_dec_same");

        press(4'b0101);
        capture(4'h0, -1);
        check_c(2, "def_over_inc");

        key = 4'hE;
        repeat (3) @(negedge clk);
        key = 4'hF;
        repeat (12) @(negedge clk);
        capture(4'h0, -1);
        check_c(2, "glitch");

        press(4'b1000);
        capture(4'h0, -1);
        chk("inv_border", 32'(fb[idx(16, 4)]), 32'h333);
        chk("inv_fill", 32'(fb[idx(20, 6)]), 32'hFFF);
        chk("inv_blank_left", 32'(fb[idx(15, 4)]), 32'h000);
        chk("inv_blank_top", 32'(fb[idx(30, 2)]), 32'h000);

        press(4'b0001);
        wait_fs();
        repeat (idx(50, 10)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_outputs", 32'({r, g, b, hs, vs, fs}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_fs", 32'({fs, hs, vs}), 32'b100);
        capture(4'h0, -1);
        check_c(2, "after_reset");
        chk("after_reset_noinv", 32'(fb[idx(16, 4)]), 32'hCCC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
